gridworld_env: RTL and testbench
================================

GRIDWORLD_ENV -- requirements
Module: gridworld_env

Interface
REQ-001 clk  input  1  clock; all logic on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 controller  input  4  phase count from the control unit; 0 in reset, then 1..10 repeating.
REQ-004 step  input  4  step index within the episode, 0..15.
REQ-005 action  input  2  agent action: 0 up, 1 down, 2 left, 3 right.
REQ-006 action_valid  input  1  action qualifier.
REQ-007 st  output  4  current state; row = st[3:2], col = st[1:0] on a 4x4 grid.
REQ-008 st1  output  4  next state; consumed by the control unit for terminal detection.
REQ-009 reward  output  8  signed reward of the last move.
REQ-010 done  output  1  one-cycle episode-end pulse.
REQ-011 ep_return  output  16  signed accumulated return of the last finished episode.
REQ-012 ep_return_valid  output  1  one-cycle pulse, coincident with done.

Function
REQ-013 The block SHALL be a phase-driven FSM with states IDLE, WAIT_ACT, WAIT_MOVE and WAIT_COMMIT, advanced only by the controller value.
REQ-014 IDLE SHALL exit to WAIT_ACT on the first cycle with controller==1.
REQ-015 At controller==2, the block SHALL latch action if action_valid=1; otherwise it SHALL hold the previously latched action.
REQ-016 At controller==5, the block SHALL register st1 and reward from st and the latched action; the values SHALL be visible from the following cycle.
REQ-017 Move rules: up = st-4, down = st+4, left = st-1, right = st+1.
REQ-018 A move leaving the grid (row 0 up, row 3 down, col 0 left, col 3 right) SHALL give st1=st and reward=-2.
REQ-019 A move landing on GOAL_STATE (9) SHALL give reward=+10.
REQ-020 Any other legal move SHALL give reward=-1.
REQ-021 At controller==10, the block SHALL add reward (sign-extended) into an internal 16-bit accumulator, saturating at +32767 and -32768.
REQ-022 Commit at controller==10: if st1==9 or step==15, the block SHALL do all of the following in the same cycle:
- pulse done and ep_return_valid for one cycle;
- load ep_return with the accumulator value including this move;
- clear the accumulator;
- load st with START_STATE (0).
REQ-023 Otherwise, at controller==10, st SHALL load st1 and the FSM SHALL return to WAIT_ACT.
REQ-024 The block SHALL treat st1==9 and step==15 in the same commit as a single episode end: one done pulse.
REQ-025 After an episode end, st1 SHALL hold the terminal value until the next controller==5.
REQ-026 ep_return SHALL hold its value between pulses.
REQ-027 The block SHALL ignore controller values other than 1, 2, 5 and 10, with no state change.

Reset
REQ-028 Reset SHALL force st=0, st1=0, reward=0, done=0, ep_return=0, ep_return_valid=0, accumulator=0, latched action=0 and FSM=IDLE.
REQ-029 Reset SHALL have priority over every phase action; a reset mid-episode SHALL discard the partial return with no done pulse.

Configuration
REQ-030 The walls feature SHALL be compiled in by the macro GRIDWORLD_WALLS_EN.
REQ-031 With GRIDWORLD_WALLS_EN defined:
- states 5 and 10 SHALL be walls;
- a move into a wall SHALL give st1=st and reward=-5;
- the out-of-grid check SHALL take precedence over the wall check.
REQ-032 Without GRIDWORLD_WALLS_EN, states 5 and 10 SHALL be ordinary cells and no -5 reward SHALL exist.

Structure
REQ-033 Shared package dqn_pkg SHALL hold:
- GOAL_STATE=9 and START_STATE=0;
- phase constants PH_START=1, PH_ACT=2, PH_MOVE=5, PH_COMMIT=10;
- reward constants R_GOAL, R_STEP, R_EDGE, R_WALL;
- the action enum and the FSM state enum.
REQ-034 The move/reward calculation SHALL be a combinational sub-module gridworld_move (inputs: state, action; outputs: next state, reward).

Verification
REQ-035 Reset for 2 cycles, then release -> all outputs 0 and FSM in IDLE until controller==1.
REQ-036 From st=0, actions right, down, down, right over four phase cycles -> st1 sequence 1, 5, 9, 10? No: the path 0 -> 1 -> 5 -> 9 reaches goal on the third move; rewards -1, -1, +10; at the third commit, done=1, ep_return=8 and st resets to 0. (Walls off.)
REQ-037 st=0 with action up -> st1=0, reward=-2; at st=3 with action right -> st1=3, reward=-2.
REQ-038 Fifteen -1 moves, then commit with step==15 and st1!=9 -> one done pulse, ep_return=-16 with the 16th move included, st=0.
REQ-039 GRIDWORLD_WALLS_EN defined, st=1, action down -> st1=1, reward=-5; same stimulus with the macro undefined -> st1=5, reward=-1.
REQ-040 Hold action_valid=0 at phase 2 after a latched action of right -> right is reused; assert rst at controller==7 mid-episode -> no done pulse, ep_return unchanged at 0, st=0.

Source files
------------

// File: rtl/dqn_pkg.sv
// dqn_pkg: shared constants and types for the gridworld environment.
//   - grid landmarks (goal, start) and the last step index of an episode
//   - controller phase numbers that trigger each FSM action
//   - signed 8-bit reward values
//   - agent action encoding and environment FSM state encoding
package dqn_pkg;

  localparam logic [3:0] GOAL_STATE  = 4'd9;
  localparam logic [3:0] START_STATE = 4'd0;
  localparam logic [3:0] LAST_STEP   = 4'd15;

  localparam logic [3:0] PH_START  = 4'd1;
  localparam logic [3:0] PH_ACT    = 4'd2;
  localparam logic [3:0] PH_MOVE   = 4'd5;
  localparam logic [3:0] PH_COMMIT = 4'd10;

  localparam logic signed [7:0] R_GOAL = 8'sd10;
  localparam logic signed [7:0] R_STEP = -8'sd1;
  localparam logic signed [7:0] R_EDGE = -8'sd2;
  localparam logic signed [7:0] R_WALL = -8'sd5;

  typedef enum logic [1:0] {
    ACT_UP    = 2'd0,
    ACT_DOWN  = 2'd1,
    ACT_LEFT  = 2'd2,
    ACT_RIGHT = 2'd3
  } action_e;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_ACT    = 2'd1,
    S_WAIT_MOVE   = 2'd2,
    S_WAIT_COMMIT = 2'd3
  } env_state_e;

endpackage

// File: rtl/gridworld_move.sv
// gridworld_move: combinational move/reward rule for a 4x4 grid.
// Build option: GRIDWORLD_WALLS_EN makes cells 5 and 10 impassable walls.
// Ports:
//   state      in  [3:0]  current cell, row = [3:2], col = [1:0]
//   action     in  action_e
//   next_state out [3:0]  resulting cell (unchanged when the move is blocked)
//   reward     out signed [7:0]
module gridworld_move
  import dqn_pkg::*;
(
  input  logic              [3:0] state,
  input  action_e                 action,
  output logic              [3:0] next_state,
  output logic signed       [7:0] reward
);

`ifdef GRIDWORLD_WALLS_EN
  localparam logic [3:0] WALL_A = 4'd5;
  localparam logic [3:0] WALL_B = 4'd10;
`endif

  logic [1:0] row;
  logic [1:0] col;
  logic [3:0] target;
  logic       off_grid;

  assign row = state[3:2];
  assign col = state[1:0];

  always_comb begin
    off_grid = 1'b0;
    target   = state;
    case (action)
      ACT_UP:    begin off_grid = (row == 2'd0); target = state - 4'd4; end
      ACT_DOWN:  begin off_grid = (row == 2'd3); target = state + 4'd4; end
      ACT_LEFT:  begin off_grid = (col == 2'd0); target = state - 4'd1; end
      ACT_RIGHT: begin off_grid = (col == 2'd3); target = state + 4'd1; end
      default:   begin off_grid = 1'b0;          target = state;        end
    endcase
  end

  // Edge check wins over the wall check: a blocked edge move never sees a wall.
  always_comb begin
    next_state = target;
    reward     = R_STEP;
    if (off_grid) begin
      next_state = state;
      reward     = R_EDGE;
    end
`ifdef GRIDWORLD_WALLS_EN
    else if ((target == WALL_A) || (target == WALL_B)) begin
      next_state = state;
      reward     = R_WALL;
    end
`endif
    else if (target == GOAL_STATE) begin
      reward = R_GOAL;
    end
  end

endmodule

// File: rtl/gridworld_env.sv
// gridworld_env: phase-driven 4x4 gridworld environment for a DQN agent.
// Build option: GRIDWORLD_WALLS_EN (passed through to gridworld_move).
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   controller [3:0]  phase count from the control unit (1..10 repeating)
//   step       [3:0]  step index within the episode
//   action     [1:0]  agent action, sampled at phase 2 when action_valid
//   action_valid      action qualifier
//   st         [3:0]  current state
//   st1        [3:0]  next state registered at phase 5
//   reward     signed [7:0]   reward of the last move
//   done              one-cycle episode-end pulse
//   ep_return  signed [15:0]  return of the last finished episode
//   ep_return_valid   one-cycle pulse coincident with done
module gridworld_env
  import dqn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic       [3:0]  controller,
  input  logic       [3:0]  step,
  input  logic       [1:0]  action,
  input  logic              action_valid,
  output logic       [3:0]  st,
  output logic       [3:0]  st1,
  output logic signed [7:0] reward,
  output logic              done,
  output logic signed [15:0] ep_return,
  output logic              ep_return_valid
);

  env_state_e               state_q, state_d;
  action_e                  act_q;
  logic signed [15:0]       acc_q;
  logic signed [15:0]       acc_sum;
  logic                     latch_en, move_en, commit_en;
  logic                     episode_end;
  logic               [3:0] mv_st1;
  logic signed        [7:0] mv_reward;

  function automatic logic signed [15:0] sat_add16(input logic signed [15:0] a,
                                                   input logic signed [7:0]  b);
    logic [16:0] s;
    s = {a[15], a} + {{9{b[7]}}, b};
    // Overflow shows up as the two top bits disagreeing; s[16] is the true sign.
    if (s[16] != s[15]) return s[16] ? 16'sh8000 : 16'sh7fff;
    return s[15:0];
  endfunction

  gridworld_move u_move (
    .state      (st),
    .action     (act_q),
    .next_state (mv_st1),
    .reward     (mv_reward)
  );

  assign acc_sum     = sat_add16(acc_q, reward);
  assign episode_end = (st1 == GOAL_STATE) || (step == LAST_STEP);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Each wait state reacts to exactly one phase value; all others are ignored.
  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    move_en   = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      S_IDLE:
        if (controller == PH_START) state_d = S_WAIT_ACT;
      S_WAIT_ACT:
        if (controller == PH_ACT) begin
          latch_en = 1'b1;
          state_d  = S_WAIT_MOVE;
        end
      S_WAIT_MOVE:
        if (controller == PH_MOVE) begin
          move_en = 1'b1;
          state_d = S_WAIT_COMMIT;
        end
      S_WAIT_COMMIT:
        if (controller == PH_COMMIT) begin
          commit_en = 1'b1;
          state_d   = S_WAIT_ACT;
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= START_STATE;
      st1             <= 4'd0;
      reward          <= '0;
      done            <= 1'b0;
      ep_return       <= '0;
      ep_return_valid <= 1'b0;
      acc_q           <= '0;
      act_q           <= ACT_UP;
    end else begin
      done            <= 1'b0;
      ep_return_valid <= 1'b0;
      if (latch_en && action_valid) act_q <= action_e'(action);
      if (move_en) begin
        st1    <= mv_st1;
        reward <= mv_reward;
      end
      // Goal and last step in one commit still form a single episode end.
      if (commit_en) begin
        if (episode_end) begin
          done            <= 1'b1;
          ep_return_valid <= 1'b1;
          ep_return       <= acc_sum;
          acc_q           <= '0;
          st              <= START_STATE;
        end else begin
          acc_q <= acc_sum;
          st    <= st1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gridworld_env.sv
module tb_gridworld_env;

  logic              clk = 1'b0;
  logic              rst;
  logic        [3:0] controller;
  logic        [3:0] step;
  logic        [1:0] action;
  logic              action_valid;
  logic        [3:0] st;
  logic        [3:0] st1;
  logic signed [7:0] reward;
  logic              done;
  logic signed [15:0] ep_return;
  logic              ep_return_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] act;
    bit         vld;
    logic [3:0] stp;
    int         e_st1;
    int         e_rwd;
    bit         e_done;
    int         e_ret;
    int         e_st;
  } vec_t;

  vec_t vecs[$];

  gridworld_env dut (
    .clk             (clk),
    .rst             (rst),
    .controller      (controller),
    .step            (step),
    .action          (action),
    .action_valid    (action_valid),
    .st              (st),
    .st1             (st1),
    .reward          (reward),
    .done            (done),
    .ep_return       (ep_return),
    .ep_return_valid (ep_return_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] a, input bit v, input logic [3:0] s,
                     input int e1, input int er, input bit ed, input int eret, input int est);
    vec_t x;
    x.act = a; x.vld = v; x.stp = s; x.e_st1 = e1; x.e_rwd = er;
    x.e_done = ed; x.e_ret = eret; x.e_st = est;
    vecs.push_back(x);
  endtask

  task automatic tick(input logic [3:0] ph);
    controller = ph;
    @(posedge clk); #1;
  endtask

  // One full phase cycle 1..10 applying one move.
  task automatic run_vec(input string tag, input vec_t v);
    for (int ph = 1; ph <= 10; ph++) begin
      action       = v.act;
      action_valid = (ph == 2) ? v.vld : 1'b0;
      step         = v.stp;
      tick(4'(ph));
      if (ph == 1) chk({tag, "_done_clear"}, int'(done), 0);
      if (ph == 5) begin
        chk({tag, "_st1"}, int'(st1), v.e_st1);
        chk({tag, "_reward"}, int'(reward), v.e_rwd);
      end
      if (ph == 10) begin
        chk({tag, "_done"}, int'(done), int'(v.e_done));
        chk({tag, "_retv"}, int'(ep_return_valid), int'(v.e_done));
        chk({tag, "_ret"}, int'(ep_return), v.e_ret);
        chk({tag, "_st"}, int'(st), v.e_st);
        chk({tag, "_st1_hold"}, int'(st1), v.e_st1);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_st"}, int'(st), 0);
    chk({tag, "_st1"}, int'(st1), 0);
    chk({tag, "_reward"}, int'(reward), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_ret"}, int'(ep_return), 0);
    chk({tag, "_retv"}, int'(ep_return_valid), 0);
  endtask

  initial begin
    int   prev;
    vec_t v;

    // Episode 1: edges, invalid-action reuse, goal at step 11 (return -4).
    add(2'd0, 1'b1, 4'd0,   0, -2, 1'b0,  0,  0);
    add(2'd2, 1'b1, 4'd1,   0, -2, 1'b0,  0,  0);
    add(2'd3, 1'b1, 4'd2,   1, -1, 1'b0,  0,  1);
    add(2'd3, 1'b1, 4'd3,   2, -1, 1'b0,  0,  2);
    add(2'd3, 1'b1, 4'd4,   3, -1, 1'b0,  0,  3);
    add(2'd3, 1'b1, 4'd5,   3, -2, 1'b0,  0,  3);
    add(2'd1, 1'b1, 4'd6,   7, -1, 1'b0,  0,  7);
    add(2'd0, 1'b0, 4'd7,  11, -1, 1'b0,  0, 11);
    add(2'd1, 1'b1, 4'd8,  15, -1, 1'b0,  0, 15);
    add(2'd2, 1'b1, 4'd9,  14, -1, 1'b0,  0, 14);
    add(2'd3, 1'b0, 4'd10, 13, -1, 1'b0,  0, 13);
    add(2'd0, 1'b1, 4'd11,  9, 10, 1'b1, -4,  0);
    // Episode 2: right, down, down (through cell 5), then a step-15 move.
    add(2'd3, 1'b1, 4'd0,   1, -1, 1'b0, -4,  1);
`ifdef GRIDWORLD_WALLS_EN
    add(2'd1, 1'b1, 4'd1,   1, -5, 1'b0, -4,  1);
    add(2'd1, 1'b1, 4'd2,   1, -5, 1'b0, -4,  1);
    add(2'd3, 1'b1, 4'd15,  2, -1, 1'b1, -12, 0);
    prev = -12;
`else
    add(2'd1, 1'b1, 4'd1,   5, -1, 1'b0, -4,  5);
    add(2'd1, 1'b1, 4'd2,   9, 10, 1'b1,  8,  0);
    add(2'd3, 1'b1, 4'd15,  1, -1, 1'b1, -1,  0);
    prev = -1;
`endif
    // Episode 3: sixteen -1 moves bouncing 0<->1, ends on step 15 with -16.
    for (int i = 0; i < 16; i++) begin
      if (i == 15)         add(2'd2, 1'b1, 4'(i), 0, -1, 1'b1, -16, 0);
      else if (i % 2 == 0) add(2'd3, 1'b1, 4'(i), 1, -1, 1'b0, prev, 1);
      else                 add(2'd2, 1'b1, 4'(i), 0, -1, 1'b0, prev, 0);
    end
    // Episode 4: goal reached on step 15 -> exactly one pulse, return 8.
    add(2'd1, 1'b1, 4'd0,   4, -1, 1'b0, -16, 4);
    add(2'd1, 1'b1, 4'd1,   8, -1, 1'b0, -16, 8);
    add(2'd3, 1'b1, 4'd15,  9, 10, 1'b1,  8,  0);

    rst = 1'b1; controller = 4'd0; step = 4'd0; action = 2'd0; action_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick(4'd0);
    chk_all_zero("reset");

    // Still in IDLE: phase actions without a prior phase 1 must do nothing.
    action = 2'd0; action_valid = 1'b1;
    tick(4'd2);
    tick(4'd5);
    tick(4'd10);
    chk_all_zero("idle");

    // Latched right reused when action_valid is low, then reset mid-episode.
    v.act = 2'd3; v.vld = 1'b1; v.stp = 4'd0; v.e_st1 = 1; v.e_rwd = -1;
    v.e_done = 1'b0; v.e_ret = 0; v.e_st = 1;
    run_vec("reuse0", v);
    v.act = 2'd2; v.vld = 1'b0; v.stp = 4'd1; v.e_st1 = 2; v.e_st = 2;
    run_vec("reuse1", v);
    action_valid = 1'b0;
    for (int ph = 1; ph <= 6; ph++) tick(4'(ph));
    rst = 1'b1;
    tick(4'd7);
    chk("midrst_done0", int'(done), 0);
    tick(4'd0);
    chk("midrst_done1", int'(done), 0);
    rst = 1'b0;
    tick(4'd0);
    chk_all_zero("midrst");

    for (int i = 0; i < vecs.size(); i++) run_vec($sformatf("v%0d", i), vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
